mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and mult_div_unit:
// operand/op issue, MTHI/MTLO writes, and the busy/done/HI/LO results.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, hi_we, lo_we, wr_data,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wr_data,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style MULT/MULTU (and DIV/DIVU when MDU_DIV_EN is defined)
// with HI/LO result registers; 32 iterations, one sign-fix cycle, one commit cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             commit_q, commit_d;

    logic             sgn;
    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b, addend;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;
`ifdef MDU_DIV_EN
    logic             div_q, div_d;
    logic             bz_q, bz_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   shifted;
    logic             ge;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        commit_d = commit_q;
`ifdef MDU_DIV_EN
        div_d    = div_q;
        bz_d     = bz_q;
        rneg_d   = rneg_q;
        a_d      = a_q;
        shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        ge       = shifted >= {1'b0, m_q};
        accept   = bus.start;
`else
        accept   = bus.start && !bus.op[1];
`endif
        sgn    = ~bus.op[0];
        mag_a  = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        mag_b  = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        addend = acc_lo_q[0] ? m_q : '0;
        sum    = {1'b0, acc_hi_q} + {1'b0, addend};
        prod   = {acc_hi_q, acc_lo_q};

        unique case (state_q)
            IDLE: begin
                // The result is held one cycle after FIX so HI/LO and done change together.
                if (commit_q) begin
                    hi_d     = acc_hi_q;
                    lo_d     = acc_lo_q;
                    done_d   = 1'b1;
                    commit_d = 1'b0;
                end else if (bus.start) begin
                    if (accept) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        acc_hi_d = '0;
                        neg_d    = sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`ifdef MDU_DIV_EN
                        div_d  = bus.op[1];
                        bz_d   = (bus.B == '0);
                        rneg_d = sgn & bus.A[WIDTH-1];
                        a_d    = bus.A;
                        if (bus.op[1]) begin
                            acc_lo_d = mag_a;
                            m_d      = mag_b;
                        end else
`endif
                        begin
                            acc_lo_d = mag_b;
                            m_d      = mag_a;
                        end
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wr_data;
                    if (bus.lo_we) lo_d = bus.wr_data;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
`ifdef MDU_DIV_EN
                if (div_q) begin
                    acc_hi_d = ge ? shifted[WIDTH-1:0] - m_q : shifted[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
                end else
`endif
                begin
                    acc_hi_d = sum[WIDTH:1];
                    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
`ifdef MDU_DIV_EN
                if (div_q) begin
                    if (bz_q) begin
                        acc_hi_d = a_q;
                        acc_lo_d = '1;
                    end else begin
                        acc_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                        acc_lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    end
                end else
`endif
                begin
                    {acc_hi_d, acc_lo_d} = neg_q ? -prod : prod;
                end
                state_d  = IDLE;
                busy_d   = 1'b0;
                commit_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            commit_q <= 1'b0;
`ifdef MDU_DIV_EN
            div_q    <= 1'b0;
            bz_q     <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            commit_q <= commit_d;
`ifdef MDU_DIV_EN
            div_q    <= div_d;
            bz_q     <= bz_d;
            rneg_q   <= rneg_d;
            a_q      <= a_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected {HI,LO};
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [63:0] exp_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        logic [63:0] e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", {32'd0, bus.HI}, {32'd0, e[63:32]});
                check("result_lo", {32'd0, bus.LO}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit expect_run, input logic [63:0] exp,
                          input bit disturb);
        int          busy_n;
        int          done_edge;
        int          extra_done;
        logic [31:0] hi_before, lo_before;
        if (expect_run) exp_q.push_back(exp);
        hi_before = bus.HI;
        lo_before = bus.LO;
        bus.op = op; bus.A = a; bus.B = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A = ~a ^ 32'h5A5A0F0F; bus.B = b + 32'h11; bus.op = ~op;
        busy_n = 0;
        done_edge = -1;
        for (int e = 0; e <= 40; e++) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_edge = e;
                break;
            end
            if (disturb && e == 5) begin
                bus.lo_we = 1'b1; bus.wr_data = 32'hDEADBEEF;
                bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd3; bus.B = 32'd4;
            end
            if (disturb && e == 6) begin
                bus.lo_we = 1'b0; bus.start = 1'b0;
                check({name, "_lo_during_run"}, {32'd0, bus.LO}, {32'd0, lo_before});
            end
            tick();
        end
        if (expect_run) begin
            check({name, "_done_edge"}, 64'(done_edge), 64'd34);
            check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
        end else begin
            check({name, "_busy_cycles"}, 64'(busy_n), 64'd0);
            check({name, "_done_edge"}, 64'(done_edge), -64'sd1);
            check({name, "_hilo_kept"}, {bus.HI, bus.LO}, {hi_before, lo_before});
        end
        if (disturb) begin
            extra_done = 0;
            for (int e = 0; e < 40; e++) begin
                tick();
                if (bus.done === 1'b1) extra_done++;
            end
            check({name, "_single_done"}, 64'(extra_done), 64'd0);
        end
        bus.op = 2'b00; bus.A = '0; bus.B = '0;
        tick();
    endtask

    task automatic reset_mid_run();
        int dn;
        bus.op = 2'b00; bus.A = 32'd7; bus.B = 32'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        reset = 1'b1;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h12121212;
        tick();
        reset = 1'b0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("rst_run_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_run_done", {63'd0, bus.done}, 64'd0);
        check("rst_run_hilo", {bus.HI, bus.LO}, 64'd0);
        dn = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (bus.done === 1'b1) dn++;
        end
        check("rst_run_no_done", 64'(dn), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_hi", {32'd0, bus.HI}, 64'd0);
        check("reset_lo", {32'd0, bus.LO}, 64'd0);
        reset = 1'b0;
        tick();

        bus.hi_we = 1'b1; bus.wr_data = 32'hAAAA5555;
        tick();
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'd0, bus.HI}, {32'd0, 32'hAAAA5555});
        check("mthi_lo", {32'd0, bus.LO}, 64'd0);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h0F0F1234;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthilo_both", {bus.HI, bus.LO}, 64'h0F0F1234_0F0F1234);

        run_op("mult_neg",   2'b00, 32'hFFFFFFFE, 32'd3,        1'b1, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
        run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001, 1'b0);
        run_op("mult_minx1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b0);
        run_op("multu_dist", 2'b01, 32'd5,        32'd7,        1'b1, 64'h00000000_00000023, 1'b1);
`ifdef MDU_DIV_EN
        run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("divu_zero",  2'b11, 32'h12345678, 32'd0,        1'b1, 64'h12345678_FFFFFFFF, 1'b0);
        run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 1'b0);
        run_op("div_negb",   2'b10, 32'd100,      32'hFFFFFFF9, 1'b1, 64'h00000002_FFFFFFF2, 1'b0);
`else
        run_op("div_off",    2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 64'd0, 1'b0);
        run_op("divu_off",   2'b11, 32'h12345678, 32'd0,        1'b0, 64'd0, 1'b0);
`endif
        reset_mid_run();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
